rsa_word_framer: RTL

RSA_WORD_FRAMER -- requirements
Module: rsa_word_framer

---
 rtl/rsa_word_framer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rsa_word_framer.sv
// RSA word framer: packs incoming bytes into WIDTH-bit words, checks each
// word against the current modulus, hands accepted words (with a latched
// copy of the key) to an exponentiation stage, then serialises the result
// back out as bytes, MSB first.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | shifting in message bytes, waiting for a full word
// LAUNCH  | one-cycle start pulse to the exponentiation stage
// WAIT    | waiting for the exponentiation result pulse
// SEND    | emitting result bytes, stalled while the sink is busy

module rsa_word_framer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    input  logic [WIDTH-1:0] key_exponent_in,
    input  logic [WIDTH-1:0] key_modulus_in,
    output logic [WIDTH-1:0] exp_value_out,
    output logic [WIDTH-1:0] exp_exponent_out,
    output logic [WIDTH-1:0] exp_modulus_out,
    output logic             exp_ready_out,
    input  logic             exp_valid_in,
    input  logic [WIDTH-1:0] exp_result_in,
    output logic [7:0]       byte_out,
    output logic             byte_valid_out,
    input  logic             tx_busy_in,
    output logic             busy_out,
    output logic             error_out,
    output logic             overrun_out
);

    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_LAUNCH  = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only the low WIDTH-8 bits of a partial word are ever needed: the
    // final byte completes the word combinationally.
    logic [WIDTH-9:0] part_q, part_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] expo_q, expo_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] full_word;
    logic             send_now;

    assign full_word = {part_q, byte_in};
    assign send_now  = (state_q == ST_SEND) && !tx_busy_in;

    // Next-state and datapath update for all four states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        value_d = value_q;
        expo_d  = expo_q;
        mod_d   = mod_q;
        res_d   = res_q;
        err_d   = 1'b0;
        ovr_d   = byte_valid_in && (state_q != ST_COLLECT);

        case (state_q)
            ST_COLLECT: begin
                if (byte_valid_in) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d  = '0;
                        part_d = '0;
                        if (full_word < key_modulus_in) begin
                            value_d = full_word;
                            expo_d  = key_exponent_in;
                            mod_d   = key_modulus_in;
                            state_d = ST_LAUNCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        part_d = full_word[WIDTH-9:0];
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (exp_valid_in) begin
                    res_d   = exp_result_in;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send_now) begin
                    res_d = {res_q[WIDTH-9:0], 8'h00};
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_COLLECT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            part_q  <= '0;
            value_q <= '0;
            expo_q  <= '0;
            mod_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            value_q <= value_d;
            expo_q  <= expo_d;
            mod_q   <= mod_d;
            res_q   <= res_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    // Output decode; byte_valid_out follows tx_busy_in within the cycle.
    always_comb begin
        exp_value_out    = value_q;
        exp_exponent_out = expo_q;
        exp_modulus_out  = mod_q;
        exp_ready_out    = (state_q == ST_LAUNCH);
        byte_out         = res_q[WIDTH-1:WIDTH-8];
        byte_valid_out   = send_now;
        busy_out         = (state_q != ST_COLLECT);
        error_out        = err_q;
        overrun_out      = ovr_q;
    end

endmodule
